// File: rtl/seg_disp_pkg.sv
// Shared constants, converter states and segment helpers for seg_display_ctrl.
// No ports; imported by bcd_seq_conv and seg_display_ctrl.
package seg_disp_pkg;

    localparam logic [2:0] OP_LED = 3'b000;
    localparam logic [2:0] OP_CYC = 3'b001;
    localparam logic [2:0] OP_UNC = 3'b011;
    localparam logic [2:0] OP_CND = 3'b111;
    localparam logic [2:0] OP_BUB = 3'b100;
    localparam logic [2:0] OP_RAM = 3'b010;

    localparam logic [31:0] BCD_MAX = 32'd99_999_999;
    localparam logic [31:0] BCD_SAT = 32'h9999_9999;

    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } conv_state_e;

    // Active-low pattern, DP (bit 7) always off.
    function automatic logic [7:0] seg_pattern(input logic [3:0] nib);
        logic [7:0] p;
        unique case (nib)
            4'h0: p = 8'b1100_0000;
            4'h1: p = 8'b1111_1001;
            4'h2: p = 8'b1010_0100;
            4'h3: p = 8'b1011_0000;
            4'h4: p = 8'b1001_1001;
            4'h5: p = 8'b1001_0010;
            4'h6: p = 8'b1000_0010;
            4'h7: p = 8'b1111_1000;
            4'h8: p = 8'b1000_0000;
            4'h9: p = 8'b1001_0000;
            4'hA: p = 8'b1000_1000;
            4'hB: p = 8'b1000_0011;
            4'hC: p = 8'b1100_0110;
            4'hD: p = 8'b1010_0001;
            4'hE: p = 8'b1000_0110;
            default: p = 8'b1000_1110;
        endcase
        return p;
    endfunction

    // Double-dabble correction: +3 on every nibble >= 5.
    function automatic logic [31:0] bcd_adjust(input logic [31:0] bcd);
        logic [31:0] r;
        logic [3:0]  nib;
        r = bcd;
        for (int i = 0; i < 8; i++) begin
            nib = bcd[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            r[4*i +: 4] = nib;
        end
        return r;
    endfunction

    // Index of the most-significant nonzero nibble; 0 when all zero.
    function automatic logic [2:0] msd_index(input logic [31:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] != 4'h0) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Sequential 32-bit binary to 8-digit BCD converter (double dabble), saturating.
// Ports: clk, rst, start_i, value_i[31:0] -> busy_o, done_o, result_o[31:0].
module bcd_seq_conv
    import seg_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] value_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    conv_state_e state_q, state_d;
    logic [31:0] bin_q;
    logic [31:0] bcd_q;
    logic [4:0]  cnt_q;
    logic        sat_q;
    logic [31:0] adj;

    assign adj = bcd_adjust(bcd_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cnt_q == 5'd0) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bin_q <= value_i;
                    end
                end
                LOAD: begin
                    bcd_q <= '0;
                    cnt_q <= 5'd31;
                    sat_q <= (bin_q > BCD_MAX);
                end
                SHIFT: begin
                    bcd_q <= {adj[30:0], bin_q[31]};
                    bin_q <= {bin_q[30:0], 1'b0};
                    cnt_q <= cnt_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == COMMIT);
    assign result_o = sat_q ? BCD_SAT : bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// 8-digit seven-segment controller: frame snapshot, BCD conversion, scan/decode.
// Ports: clk, rst, led_cpu_enable, display_op[2:0], six 32-bit sources -> SEG, AN, busy.
// Option: define LEADING_ZERO_BLANK_EN to blank digits above the leading nonzero one.
module seg_display_ctrl
    import seg_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        led_cpu_enable,
    input  logic [2:0]  display_op,
    input  logic [31:0] led_data_in,
    input  logic [31:0] total_cycles,
    input  logic [31:0] uncondi_branch_num,
    input  logic [31:0] condi_branch_num,
    input  logic [31:0] bubble_num,
    input  logic [31:0] ram_display_data_out,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        busy
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_q, digit_d;
    logic [31:0]   disp_q, disp_d;
    logic [7:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;

    logic          wrap;
    logic          frame_end;
    logic          snap;
    logic [31:0]   src_val;
    logic          src_dec;
    logic          src_wr;
    logic          conv_busy;
    logic          conv_done;
    logic [31:0]   conv_res;
    logic [3:0]    nib;

    assign wrap      = (presc_q == PRESC_MAX);
    assign frame_end = wrap && (digit_q == 3'd7);
    // A frame end during a conversion is dropped, not queued.
    assign snap      = frame_end && !conv_busy;

    always_comb begin
        src_val = '0;
        src_dec = 1'b0;
        src_wr  = 1'b0;
        unique case (display_op)
            OP_LED: begin
                src_val = led_data_in;
                src_wr  = led_cpu_enable;
            end
            OP_CYC: begin
                src_val = total_cycles;
                src_dec = 1'b1;
            end
            OP_UNC: begin
                src_val = uncondi_branch_num;
                src_dec = 1'b1;
            end
            OP_CND: begin
                src_val = condi_branch_num;
                src_dec = 1'b1;
            end
            OP_BUB: begin
                src_val = bubble_num;
                src_dec = 1'b1;
            end
            OP_RAM: begin
                src_val = ram_display_data_out;
                src_wr  = 1'b1;
            end
            default: begin
                src_val = '0;
                src_wr  = 1'b1;
            end
        endcase
    end

    bcd_seq_conv u_conv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (snap && src_dec),
        .value_i  (src_val),
        .busy_o   (conv_busy),
        .done_o   (conv_done),
        .result_o (conv_res)
    );

    always_comb begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        digit_d = wrap ? digit_q + 3'd1 : digit_q;

        disp_d = disp_q;
        if (conv_done) begin
            disp_d = conv_res;
        end else if (snap && src_wr) begin
            disp_d = src_val;
        end

        nib   = disp_q[{digit_q, 2'b00} +: 4];
        seg_d = seg_pattern(nib);
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_q > msd_index(disp_q)) begin
            seg_d = SEG_BLANK;
        end
`endif
        an_d = ~(8'b0000_0001 << digit_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            digit_q <= '0;
            disp_q  <= '0;
            seg_q   <= 8'b1100_0000;
            an_q    <= 8'b1111_1110;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign SEG  = seg_q;
    assign AN   = an_q;
    assign busy = conv_busy;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized self-checking bench for seg_display_ctrl at SCAN_DIV=4.
// Reference model works from frame timing and decimal arithmetic.
module tb_seg_display_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        led_cpu_enable;
    logic [2:0]  display_op;
    logic [31:0] led_data_in;
    logic [31:0] total_cycles;
    logic [31:0] uncondi_branch_num;
    logic [31:0] condi_branch_num;
    logic [31:0] bubble_num;
    logic [31:0] ram_display_data_out;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          n;
    logic [31:0] m_disp;
    int          m_busy;
    logic [31:0] m_pend;
    logic [7:0]  exp_an;
    logic [7:0]  exp_seg;

    logic [7:0] pat [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg_display_ctrl #(.SCAN_DIV(DIV)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .led_cpu_enable       (led_cpu_enable),
        .display_op           (display_op),
        .led_data_in          (led_data_in),
        .total_cycles         (total_cycles),
        .uncondi_branch_num   (uncondi_branch_num),
        .condi_branch_num     (condi_branch_num),
        .bubble_num           (bubble_num),
        .ram_display_data_out (ram_display_data_out),
        .SEG                  (SEG),
        .AN                   (AN),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] x;
        if (v > 32'd99_999_999) return 32'h9999_9999;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_exp(input logic [31:0] d, input int dig);
        logic [3:0] nb;
        nb = d[4*dig +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int msd = 0;
            for (int i = 0; i < 8; i++)
                if (d[4*i +: 4] != 4'h0) msd = i;
            if (dig > msd) return 8'hFF;
        end
`endif
        return pat[nb];
    endfunction

    task automatic start_dec(input logic [31:0] v);
        m_pend = to_bcd(v);
        m_busy = 34;
    endtask

    task automatic tick();
        logic [31:0] old_disp;
        int dig_old;
        bit fe;
        old_disp = m_disp;
        dig_old  = (n / DIV) % 8;
        @(posedge clk);
        if (rst) begin
            n = 0;
            m_disp = '0;
            m_busy = 0;
            exp_an = 8'hFE;
            exp_seg = 8'hC0;
        end else begin
            fe = (n % FRAME) == FRAME - 1;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_disp = m_pend;
            end else if (fe) begin
                case (display_op)
                    3'b000: if (led_cpu_enable) m_disp = led_data_in;
                    3'b001: start_dec(total_cycles);
                    3'b011: start_dec(uncondi_branch_num);
                    3'b111: start_dec(condi_branch_num);
                    3'b100: start_dec(bubble_num);
                    3'b010: m_disp = ram_display_data_out;
                    default: m_disp = '0;
                endcase
            end
            exp_an  = ~(8'b1 << dig_old);
            exp_seg = seg_exp(old_disp, dig_old);
            n++;
        end
        #1;
        chk("AN", 32'(AN), 32'(exp_an));
        chk("SEG", 32'(SEG), 32'(exp_seg));
        chk("busy", 32'(busy), 32'(m_busy > 0));
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    task automatic wait_busy(input int target);
        for (int k = 0; k < 200; k++) begin
            if (m_busy == target) return;
            tick();
        end
        chk("wait_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        unique case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 999));
            1: return 32'($urandom_range(0, 99_999_999));
            2: return 32'd99_999_999 + 32'($urandom_range(0, 2));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n = 0;
        m_disp = '0;
        m_busy = 0;
        m_pend = '0;
        rst = 1'b1;
        led_cpu_enable = 1'b0;
        display_op = 3'b000;
        led_data_in = '0;
        total_cycles = '0;
        uncondi_branch_num = '0;
        condi_branch_num = '0;
        bubble_num = '0;
        ram_display_data_out = '0;
        run(2);
        rst = 1'b0;
        run(6);

        display_op = 3'b001;
        total_cycles = 32'd1234;
        run(3 * FRAME);

        display_op = 3'b000;
        led_cpu_enable = 1'b0;
        led_data_in = 32'hDEAD_BEEF;
        run(2 * FRAME);
        led_cpu_enable = 1'b1;
        run(2 * FRAME);

        display_op = 3'b011;
        uncondi_branch_num = 32'd100_000_000;
        run(3 * FRAME);
        display_op = 3'b111;
        condi_branch_num = 32'd5_678;
        wait_busy(20);
        condi_branch_num = 32'd87_654_321;
        run(4 * FRAME);

        display_op = 3'b001;
        total_cycles = 32'd424_242;
        run(FRAME);
        wait_busy(34);
        run(10);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(3 * FRAME);

        display_op = 3'b100;
        bubble_num = 32'd42;
        run(3 * FRAME);
        bubble_num = 32'd0;
        run(3 * FRAME);

        for (int it = 0; it < 60; it++) begin
            display_op = 3'($urandom_range(0, 7));
            led_cpu_enable = 1'($urandom_range(0, 1));
            led_data_in = $urandom;
            total_cycles = rnd_val();
            uncondi_branch_num = rnd_val();
            condi_branch_num = rnd_val();
            bubble_num = rnd_val();
            ram_display_data_out = $urandom;
            run($urandom_range(5, 70));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
